// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin grant arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int              NREQ       = 4;
    localparam logic [NREQ-1:0] GRANT_NONE = 4'b1111;

    // Returns {found, idx}: first set request after last, wrapping back to last itself.
    function automatic logic [2:0] rr_next(input logic [1:0] last, input logic [NREQ-1:0] req);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int k = NREQ; k >= 1; k--) begin
            c = last + 2'(k);
            if (req[c]) r = {1'b1, c};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_decoder_arbiter_dec.sv
// Combinational 2-to-4 decoder with active-low enable and active-low outputs.
module dec2to4_n
    import rr_arb_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       en_n,
    output logic [3:0] y_n
);

    always_comb begin
        y_n = GRANT_NONE;
        if (!en_n) y_n[sel] = 1'b0;
    end

endmodule

// File: rtl/rr_grant_decoder_arbiter.sv
// Round-robin arbiter for four requesters with hold-time preemption, a one-cycle
// dead gap between owners and a global enable; grant bus is a registered decode.
module rr_grant_decoder_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_arb_en,
    input  logic [3:0] i_req,
    output logic [3:0] o_grant_n,
    output logic [1:0] o_grant_idx,
    output logic       o_grant_valid,
    output logic       o_timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic              LIMIT_ON   = (MAX_HOLD != 0);

    state_t            r_state;
    logic [1:0]        r_last_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [3:0]        r_grant_n;
    logic [1:0]        r_grant_idx;
    logic              r_grant_valid;
    logic              r_timeout;

    state_t            w_nxt_state;
    logic [1:0]        w_nxt_last;
    logic [HOLD_W-1:0] w_nxt_hold;
    logic [1:0]        w_nxt_idx;
    logic              w_nxt_valid;
    logic              w_nxt_timeout;
    logic [2:0]        w_pick;
    logic              w_win;
    logic [3:0]        w_dec_n;

    always_comb begin
        w_pick        = rr_next(r_last_ptr, i_req);
        w_win         = i_arb_en & w_pick[2];
        w_nxt_state   = r_state;
        w_nxt_last    = r_last_ptr;
        w_nxt_hold    = r_hold_cnt;
        w_nxt_idx     = r_grant_idx;
        w_nxt_valid   = r_grant_valid;
        w_nxt_timeout = 1'b0;

        case (r_state)
            GRANT: begin
                // Release wins over the hold limit, so a voluntary drop never pulses timeout.
                if (!i_arb_en) begin
                    w_nxt_state = IDLE;
                    w_nxt_idx   = 2'd0;
                    w_nxt_valid = 1'b0;
                    w_nxt_hold  = '0;
                end else if (!i_req[r_grant_idx]) begin
                    w_nxt_state = GAP;
                    w_nxt_idx   = 2'd0;
                    w_nxt_valid = 1'b0;
                    w_nxt_hold  = '0;
                end else if (LIMIT_ON && r_hold_cnt == HOLD_LIMIT) begin
                    w_nxt_state   = GAP;
                    w_nxt_idx     = 2'd0;
                    w_nxt_valid   = 1'b0;
                    w_nxt_hold    = '0;
                    w_nxt_timeout = 1'b1;
                end else if (r_hold_cnt != '1) begin
                    w_nxt_hold = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP just guarantees one dead cycle.
                if (w_win) begin
                    w_nxt_state = GRANT;
                    w_nxt_idx   = w_pick[1:0];
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = w_pick[1:0];
                    w_nxt_hold  = HOLD_W'(1);
                end else begin
                    w_nxt_state = IDLE;
                    w_nxt_idx   = 2'd0;
                    w_nxt_valid = 1'b0;
                    w_nxt_hold  = '0;
                end
            end
        endcase
    end

    dec2to4_n u_dec (
        .sel  (w_nxt_idx),
        .en_n (~w_nxt_valid),
        .y_n  (w_dec_n)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_last_ptr    <= 2'd3;
            r_hold_cnt    <= '0;
            r_grant_n     <= GRANT_NONE;
            r_grant_idx   <= 2'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_last_ptr    <= w_nxt_last;
            r_hold_cnt    <= w_nxt_hold;
            r_grant_n     <= w_dec_n;
            r_grant_idx   <= w_nxt_idx;
            r_grant_valid <= w_nxt_valid;
            r_timeout     <= w_nxt_timeout;
        end
    end

    assign o_grant_n     = r_grant_n;
    assign o_grant_idx   = r_grant_idx;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_decoder_arbiter.sv
// Bench for rr_grant_decoder_arbiter: directed scenarios plus random traffic,
// each checked against an owner/tenure model of the arbitration rules.
module tb_rr_grant_decoder_arbiter;

    localparam int MAXH = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arb_en;
    logic [3:0] req;
    logic [3:0] grant_n;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic [7:0] obs;

    int checks = 0;
    int errors = 0;

    // Model: current owner (-1 = none), cycles owned, last owner, timeout pulse.
    int   m_owner;
    int   m_held;
    int   m_last;
    logic m_tout;

    rr_grant_decoder_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_arb_en      (arb_en),
        .i_req         (req),
        .o_grant_n     (grant_n),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    assign obs = {grant_n, grant_idx, grant_valid, timeout};

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_tout  = 1'b0;
    endtask

    task automatic model_step();
        int   c;
        logic found;
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            if (!arb_en || !req[m_owner]) begin
                m_owner = -1;
            end else if (MAXH != 0 && m_held == MAXH) begin
                m_owner = -1;
                m_tout  = 1'b1;
            end else begin
                m_held++;
            end
        end else if (arb_en && req != 4'b0000) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                end
            end
            m_last = m_owner;
            m_held = 1;
        end
    endtask

    function automatic logic [7:0] exp_bus();
        logic [3:0] gn;
        logic [1:0] idx;
        logic       v;
        gn  = 4'hF;
        idx = 2'd0;
        v   = 1'b0;
        if (m_owner >= 0) begin
            gn[m_owner] = 1'b0;
            idx         = 2'(m_owner);
            v           = 1'b1;
        end
        return {gn, idx, v, m_tout};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        req = 4'b0000;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_out();
        req    = 4'b0000;
        arb_en = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== 8'hF0) begin
            errors++;
            $display("FAIL reset_initial got=%h want=%h", obs, 8'hF0);
        end
        rst_n  = 1'b1;
        req    = 4'b1111;
        arb_en = 1'b1;
        tick();
        checks++;
        if (grant_n !== 4'b1110 || obs !== exp_bus()) begin
            errors++;
            $display("FAIL reset_first_grant got=%h want=%h", obs, exp_bus());
        end
        repeat (2) tick();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 8'hF0) begin
            errors++;
            $display("FAIL reset_async_midgrant got=%h want=%h", obs, 8'hF0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'hF0) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", obs, 8'hF0);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (grant_n !== 4'b1110 || obs !== exp_bus()) begin
            errors++;
            $display("FAIL reset_regrant got=%h want=%h", obs, exp_bus());
        end
        idle_out();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== {4'b1011, 2'd2, 1'b1, 1'b0} || obs !== exp_bus()) begin
                errors++;
                $display("FAIL single_grant cyc=%0d got=%h want=%h", i, obs, exp_bus());
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (obs !== 8'hF0 || obs !== exp_bus()) begin
            errors++;
            $display("FAIL single_release got=%h want=%h", obs, 8'hF0);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] one;
        logic [3:0] want;
        pulse_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c % 4 < 3) begin
                one  = 4'b0001 << ((c / 4) % 4);
                want = ~one;
            end else begin
                want = 4'hF;
            end
            checks++;
            if (grant_n !== want || timeout !== 1'b0 || obs !== exp_bus()) begin
                errors++;
                $display("FAIL fairness cyc=%0d got=%h want_gn=%h model=%h", c, obs, want, exp_bus());
            end
            if (m_owner >= 0 && m_held == 3) req = 4'b1111 & ~(4'b0001 << m_owner);
            else                             req = 4'b1111;
        end
        idle_out();
    endtask

    task automatic test_hold_limit();
        pulse_reset();
        req = 4'b0010;
        for (int c = 0; c < 17; c++) begin
            if (c == 5) req = 4'b1010;
            tick();
            checks++;
            if (c < 15) begin
                if (obs !== {4'b1101, 2'd1, 1'b1, 1'b0} || obs !== exp_bus()) begin
                    errors++;
                    $display("FAIL hold_owner1 cyc=%0d got=%h want=%h", c, obs, exp_bus());
                end
            end else if (c == 15) begin
                if (obs !== {4'b1111, 2'd0, 1'b0, 1'b1} || obs !== exp_bus()) begin
                    errors++;
                    $display("FAIL hold_timeout cyc=%0d got=%h want=%h", c, obs, exp_bus());
                end
            end else begin
                if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0} || obs !== exp_bus()) begin
                    errors++;
                    $display("FAIL hold_next_owner cyc=%0d got=%h want=%h", c, obs, exp_bus());
                end
            end
        end
        idle_out();
    endtask

    task automatic test_single_hold();
        int   touts;
        logic [7:0] want;
        touts = 0;
        pulse_reset();
        req = 4'b0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            want = (c % 16 < 15) ? {4'b1110, 2'd0, 1'b1, 1'b0} : {4'b1111, 2'd0, 1'b0, 1'b1};
            if (timeout === 1'b1) touts++;
            checks++;
            if (obs !== want || obs !== exp_bus()) begin
                errors++;
                $display("FAIL single_hold cyc=%0d got=%h want=%h", c, obs, want);
            end
        end
        checks++;
        if (touts != 2) begin
            errors++;
            $display("FAIL single_hold_count got=%0d want=2", touts);
        end
        idle_out();
    endtask

    task automatic test_enable();
        pulse_reset();
        req    = 4'b0100;
        arb_en = 1'b1;
        repeat (3) tick();
        arb_en = 1'b0;
        tick();
        checks++;
        if (obs !== 8'hF0 || obs !== exp_bus()) begin
            errors++;
            $display("FAIL enable_drop got=%h want=%h", obs, 8'hF0);
        end
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 8'hF0 || obs !== exp_bus()) begin
                errors++;
                $display("FAIL enable_off_hold cyc=%0d got=%h want=%h", i, obs, 8'hF0);
            end
        end
        arb_en = 1'b1;
        req    = 4'b1000;
        tick();
        checks++;
        if (obs !== {4'b0111, 2'd3, 1'b1, 1'b0} || obs !== exp_bus()) begin
            errors++;
            $display("FAIL enable_resume got=%h want=%h", obs, exp_bus());
        end
        for (int i = 0; i < 20 && m_held != MAXH; i++) tick();
        req = 4'b0000;
        tick();
        checks++;
        if (obs !== 8'hF0 || obs !== exp_bus()) begin
            errors++;
            $display("FAIL release_at_limit got=%h want=%h", obs, 8'hF0);
        end
        idle_out();
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            arb_en = ($urandom_range(0, 15) != 0);
            tick();
            checks++;
            if (obs !== exp_bus()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h req=%b en=%b", c, obs, exp_bus(), req, arb_en);
            end
            checks++;
            if (grant_valid !== ~&grant_n || $countones(~grant_n) > 1) begin
                errors++;
                $display("FAIL random_onehot cyc=%0d grant_n=%b valid=%b", c, grant_n, grant_valid);
            end
        end
        idle_out();
    endtask

    initial begin
        rst_n  = 1'b0;
        arb_en = 1'b0;
        req    = 4'b0000;
        model_reset();
        #12;
        test_reset();
        test_single();
        test_fairness();
        test_hold_limit();
        test_single_hold();
        test_enable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
